// File: rtl/quad_pkg.sv
// Shared constants and types for the quadrature front end and decode stage.
package quad_pkg;

   localparam int QUAD_SYNC_STAGES     = 2;
   localparam int QUAD_DEBOUNCE_CYCLES = 16;

   typedef struct packed {
      logic a;
      logic b;
   } quad_pair_t;

endpackage

// File: rtl/debounce_chan.sv
// One encoder channel: synchroniser chain, consecutive-sample debounce
// counter, filtered output register and an "output updates now" flag.
module debounce_chan
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES     = QUAD_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_i,
   output logic lvl_o,
   output logic upd_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   out_q, out_d;
   logic                   s;

   assign s      = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};

   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      upd_o = 1'b0;
      if (s == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         out_d = s;
         cnt_d = '0;
         upd_o = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         out_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
      end
   end

   assign lvl_o = out_q;

endmodule

// File: rtl/quad_input_filter.sv
// Quadrature input conditioner: two debounced channels plus registered
// change and illegal-transition strobes for the decode stage.
module quad_input_filter
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES     = QUAD_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   output logic a_o,
   output logic b_o,
   output logic chg,
   output logic err
);

   quad_pair_t upd;
   logic       chg_q, chg_d;
   logic       err_q, err_d;

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_chan_a (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (a),
      .lvl_o (a_o),
      .upd_o (upd.a)
   );

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_chan_b (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (b),
      .lvl_o (b_o),
      .upd_o (upd.b)
   );

   // Both channels moving together is never a legal Gray-code step.
   assign chg_d = upd.a | upd.b;
   assign err_d = upd.a & upd.b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chg_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         chg_q <= chg_d;
         err_q <= err_d;
      end
   end

   assign chg = chg_q;
   assign err = err_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter: two configurations against a window-based
// reference model, plus literal latency/strobe expectations.
module tb_quad_input_filter;

   logic clk = 1'b0;
   logic rst_n;
   logic a, b;
   logic a0, b0, chg0, err0;
   logic a1, b1, chg1, err1;

   int n_checks = 0;
   int n_fail   = 0;
   int chgs     = 0;
   int errs     = 0;
   bit sweep_on = 0;

   always #5 clk = ~clk;

   quad_input_filter #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (3)
   ) u0 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .a_o   (a0),
      .b_o   (b0),
      .chg   (chg0),
      .err   (err0)
   );

   quad_input_filter #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1)
   ) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .a_o   (a1),
      .b_o   (b1),
      .chg   (chg1),
      .err   (err1)
   );

   function automatic int sy(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic int db(int i);
      return (i == 0) ? 3 : 1;
   endfunction

   function automatic void chk(string nm, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t",
                  nm, act, exp, $time);
      end
   endfunction

   // Reference: the output flips when the synced level seen on each of
   // the last DB edges differs from it. Synced level on an edge is the
   // pin sampled SY edges earlier (0 if that is before reset release).
   bit rawh [2][16];
   int ne = 0;
   bit mo   [2][2];
   bit mchg [2];
   bit merr [2];

   always @(posedge clk or negedge rst_n) begin
      int s_n, d_n;
      bit flip [2];
      bit sj;
      if (!rst_n) begin
         ne = 0;
         for (int i = 0; i < 2; i++) begin
            mo[i][0] = 0;
            mo[i][1] = 0;
            mchg[i]  = 0;
            merr[i]  = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            s_n = sy(i);
            d_n = db(i);
            for (int c = 0; c < 2; c++) begin
               flip[c] = (ne >= d_n - 1);
               for (int j = 0; j < d_n; j++) begin
                  sj = (ne >= s_n + j) ? rawh[c][s_n-1+j] : 1'b0;
                  if (sj == mo[i][c]) flip[c] = 0;
               end
            end
            for (int c = 0; c < 2; c++)
               if (flip[c]) mo[i][c] = ~mo[i][c];
            mchg[i] = flip[0] | flip[1];
            merr[i] = flip[0] & flip[1];
         end
         for (int c = 0; c < 2; c++)
            for (int k = 15; k > 0; k--)
               rawh[c][k] = rawh[c][k-1];
         rawh[0][0] = a;
         rawh[1][0] = b;
         if (ne < 1000) ne++;
      end
   end

   always @(negedge clk) begin
      chk("u0_a_o", a0, mo[0][0]);
      chk("u0_b_o", b0, mo[0][1]);
      chk("u0_chg", chg0, mchg[0]);
      chk("u0_err", err0, merr[0]);
      chk("u1_a_o", a1, mo[1][0]);
      chk("u1_b_o", b1, mo[1][1]);
      chk("u1_chg", chg1, mchg[1]);
      chk("u1_err", err1, merr[1]);
      if (sweep_on) begin
         chgs += int'(chg0);
         errs += int'(err0);
      end
   end

   task automatic drive(logic av, logic bv);
      @(negedge clk);
      #2;
      a = av;
      b = bv;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   // Expected u0 response over six edges to a level step ov -> nv.
   task automatic step_check(logic [1:0] ov, logic [1:0] nv);
      logic [1:0] d;
      d = ov ^ nv;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("lit_a_o", a0, (e >= 5) ? nv[1] : ov[1]);
         chk("lit_b_o", b0, (e >= 5) ? nv[0] : ov[0]);
         chk("lit_chg", chg0, (e == 5) && (d != 2'b00));
         chk("lit_err", err0, (e == 5) && (d == 2'b11));
      end
   endtask

   task automatic phase4(logic av, logic bv);
      drive(av, bv);
      idle(3);
   endtask

   initial begin
      rst_n = 1'b0;
      a = 1'b1;
      b = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_a_o", a0, 1'b0);
         chk("rst_chg", chg0, 1'b0);
      end

      @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("rel_a_o", a0, e >= 5);
         chk("rel_b_o", b0, e >= 5);
         chk("rel_chg", chg0, e == 5);
         chk("rel_err", err0, e == 5);
         chk("rel_d1_a_o", a1, e >= 4);
         chk("rel_d1_chg", chg1, e == 4);
         chk("rel_d1_err", err1, e == 4);
      end

      drive(0, 0);
      idle(8);
      drive(1, 0);
      step_check(2'b00, 2'b10);
      drive(0, 0);
      step_check(2'b10, 2'b00);

      drive(1, 0);
      tick();
      drive(0, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_a_o", a0, 1'b0);
         chk("glitch_chg", chg0, 1'b0);
      end
      drive(1, 0);
      drive(0, 0);
      drive(1, 0);
      drive(0, 0);
      drive(1, 0);
      step_check(2'b00, 2'b10);

      drive(0, 0);
      idle(8);
      drive(1, 0);
      idle(4);
      #1;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      chk("midrst_a_o", a0, 1'b0);
      step_check(2'b00, 2'b10);

      drive(0, 0);
      idle(8);
      chgs = 0;
      errs = 0;
      sweep_on = 1;
      for (int n = 0; n < 16; n++) begin
         phase4(1, 0);
         phase4(1, 1);
         phase4(0, 1);
         phase4(0, 0);
      end
      for (int n = 0; n < 16; n++) begin
         phase4(0, 1);
         phase4(1, 1);
         phase4(1, 0);
         phase4(0, 0);
      end
      idle(10);
      sweep_on = 0;
      n_checks++;
      if (chgs != 128) begin
         n_fail++;
         $display("FAIL sweep_chg_count: got %0d, expected 128", chgs);
      end
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL sweep_err_count: got %0d, expected 0", errs);
      end

      for (int n = 0; n < 200; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 5));
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
